// File: rtl/hub_link_pkg.sv
// rtl/hub_link_pkg.sv - shared constants and destination decode for the root hub link switch
package hub_link_pkg;
  localparam int HUB_DATA_WIDTH   = 64;
  localparam int HUB_ID_WIDTH     = 8;
  localparam int HUB_BROADCAST_ID = 255;
  // destination field occupies the top ID bits of every message
  localparam int HUB_DEST_MSB     = HUB_DATA_WIDTH - 1;
  localparam int HUB_DEST_LSB     = HUB_DATA_WIDTH - HUB_ID_WIDTH;

  typedef enum logic [1:0] {
    DEST_UNICAST   = 2'd0,
    DEST_BROADCAST = 2'd1,
    DEST_INVALID   = 2'd2
  } dest_kind_e;

  function automatic dest_kind_e decode_dest(input int dest, input int broadcast_id,
                                             input int num_leaves);
    dest_kind_e kind;
    if (dest == broadcast_id) kind = DEST_BROADCAST;
    else if (dest >= 1 && dest <= num_leaves) kind = DEST_UNICAST;
    else kind = DEST_INVALID;
    return kind;
  endfunction
endpackage

// File: rtl/link_fifo.sv
// rtl/link_fifo.sv - synchronous first-word-fall-through FIFO with wrap-bit pointers
module link_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage needs no reset: nothing is visible until a write moves wr_ptr
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/root_hub_link_switch.sv
// rtl/root_hub_link_switch.sv - routes controller messages to leaves and merges leaf traffic round-robin
module root_hub_link_switch
  import hub_link_pkg::*;
#(
  parameter int NUM_LEAVES   = 4,
  parameter int DATA_WIDTH   = HUB_DATA_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int ID_WIDTH     = HUB_ID_WIDTH,
  parameter int BROADCAST_ID = HUB_BROADCAST_ID
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            host_rx_data,
  input  logic                             host_rx_valid,
  output logic                             host_rx_ready,
  output logic [DATA_WIDTH-1:0]            host_tx_data,
  output logic                             host_tx_valid,
  input  logic                             host_tx_ready,
  output logic [NUM_LEAVES*DATA_WIDTH-1:0] down_tx_data,
  output logic [NUM_LEAVES-1:0]            down_tx_valid,
  input  logic [NUM_LEAVES-1:0]            down_tx_ready,
  input  logic [NUM_LEAVES*DATA_WIDTH-1:0] up_rx_data,
  input  logic [NUM_LEAVES-1:0]            up_rx_valid,
  output logic [NUM_LEAVES-1:0]            up_rx_ready,
  output logic                             bad_dest,
  output logic [15:0]                      drop_count
);
  localparam int RR_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;

  logic                  stage_v;
  logic [DATA_WIDTH-1:0] stage_d;
  logic [ID_WIDTH-1:0]   dest;
  dest_kind_e            kind;
  logic                  dispatch;
  logic [NUM_LEAVES-1:0] down_wr, down_full, down_empty;
  logic [NUM_LEAVES-1:0] up_rd, up_full, up_empty;
  logic [DATA_WIDTH-1:0] up_head [NUM_LEAVES];
  logic [RR_W-1:0]       rr, grant;
  logic                  found, load;

  assign dest          = stage_d[DATA_WIDTH-1 -: ID_WIDTH];
  assign kind          = decode_dest(int'(dest), BROADCAST_ID, NUM_LEAVES);
  assign host_rx_ready = !stage_v || dispatch;

  // broadcasts are all-or-nothing; bad destinations drain without touching any FIFO
  always_comb begin
    dispatch = 1'b0;
    down_wr  = '0;
    if (stage_v) begin
      case (kind)
        DEST_BROADCAST: begin
          dispatch = ~|down_full;
          down_wr  = {NUM_LEAVES{dispatch}};
        end
        DEST_UNICAST: begin
          for (int k = 0; k < NUM_LEAVES; k++) begin
            if (int'(dest) == k + 1) begin
              dispatch   = !down_full[k];
              down_wr[k] = !down_full[k];
            end
          end
        end
        default: dispatch = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_v    <= 1'b0;
      stage_d    <= '0;
      bad_dest   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (host_rx_valid && host_rx_ready) begin
        stage_v <= 1'b1;
        stage_d <= host_rx_data;
      end else if (dispatch) begin
        stage_v <= 1'b0;
      end
      bad_dest <= dispatch && (kind == DEST_INVALID);
      if (dispatch && (kind == DEST_INVALID) && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

  for (genvar k = 0; k < NUM_LEAVES; k++) begin : g_leaf
    link_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_down (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (down_wr[k]),
      .wr_data (stage_d),
      .rd_en   (down_tx_ready[k]),
      .rd_data (down_tx_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .full    (down_full[k]),
      .empty   (down_empty[k])
    );
    link_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_up (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (up_rx_valid[k]),
      .wr_data (up_rx_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en   (up_rd[k]),
      .rd_data (up_head[k]),
      .full    (up_full[k]),
      .empty   (up_empty[k])
    );
    assign down_tx_valid[k] = !down_empty[k];
    assign up_rx_ready[k]   = !up_full[k];
  end

  // first non-empty up FIFO at or after rr wins
  always_comb begin
    found = 1'b0;
    grant = rr;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      if (!found && !up_empty[(int'(rr) + i) % NUM_LEAVES]) begin
        found = 1'b1;
        grant = RR_W'((int'(rr) + i) % NUM_LEAVES);
      end
    end
  end

  assign load = !host_tx_valid || host_tx_ready;

  always_comb begin
    up_rd = '0;
    if (load && found) up_rd[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_tx_valid <= 1'b0;
      host_tx_data  <= '0;
      rr            <= '0;
    end else if (load) begin
      host_tx_valid <= found;
      if (found) begin
        host_tx_data <= up_head[grant];
        rr           <= RR_W'((int'(grant) + 1) % NUM_LEAVES);
      end
    end
  end
endmodule
